sh7604_wdt: RTL
===============

SH7604_WDT -- requirements
Module: SH7604_WDT

Interface
REQ-001 SHALL have parameter RST_PULSE, default 512, meaning the width of the internal reset request in CE_R ticks.
REQ-002 SHALL have port CLK  in  1  system clock; all state is updated on the rising edge only.
REQ-003 SHALL have port RST_N  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports CE_R and CE_F  in  1 each  rising and falling clock enables; EN  in  1  gates all counting and register writes.
REQ-005 SHALL have ports IBUS_A  in  32, IBUS_DI  in  32, IBUS_DO  out  32, IBUS_BA  in  4, IBUS_WE  in  1, IBUS_REQ  in  1, IBUS_BUSY  out  1, IBUS_ACT  out  1, forming the internal register bus.
REQ-006 SHALL have port SBY  in  1  standby flag from the standby controller.
REQ-007 SHALL have port WDT_OVF  out  1  one-CE_R-tick overflow pulse consumed by the standby controller.
REQ-008 SHALL have ports ITI_IRQ  out  1  interval interrupt level, WDTOVF_N  out  1  external overflow strobe (active-low), PRES  out  1  internal reset request.

Function
REQ-009 SHALL decode REG_SEL = (IBUS_A[31:2] == 30'h3FFFFFA0), which covers FFFFFE80..FFFFFE83; IBUS_ACT = REG_SEL; IBUS_BUSY = 0.
REQ-010 SHALL hold registers WTCSR[7:0] (OVF, WT/IT, TME, -, -, CKS[2:0]), WTCNT[7:0], and RSTCSR[7:0] (WOVF, RSTE, RSTS, bits 4:0 read 1).
REQ-011 SHALL accept writes only as word writes on a CE_R tick with EN=1, REG_SEL=1, IBUS_REQ=1, and IBUS_WE=1.
REQ-012 SHALL treat a write with IBUS_BA=4'b1100 as follows: DI[31:24]=8'h5A loads WTCNT<=DI[23:16]; DI[31:24]=8'hA5 loads WT/IT, TME, and CKS from DI[22:16]; any other key is ignored.
REQ-013 SHALL clear WTCSR.OVF when a keyed 8'hA5 write has DI[23]=0; a write with DI[23]=1 leaves OVF unchanged.
REQ-014 SHALL treat a write with IBUS_BA=4'b0011 as follows: DI[15:0]=16'hA500 clears WOVF; DI[15:8]=8'h5A loads RSTE<=DI[6] and RSTS<=DI[5]; any other value is ignored.
REQ-015 SHALL run a free 13-bit prescaler that increments on every CE_R tick with EN=1.
REQ-016 SHALL generate a count tick when prescaler bit N falls 1->0, with N indexed by CKS 0..7 as 0, 5, 6, 7, 8, 9, 11, 12 (divide-by 2, 64, 128, 256, 512, 1024, 4096, 8192).
REQ-017 SHALL increment WTCNT on a count tick when TME=1 or SBY=1.
REQ-018 SHALL clear WTCNT to 0 and hold it while TME=0 and SBY=0.
REQ-019 SHALL treat WTCNT wrapping 8'hFF->8'h00 as an overflow event.
REQ-020 SHALL, on an overflow with SBY=1, pulse WDT_OVF for one CE_R tick and leave OVF, WOVF, ITI_IRQ, WDTOVF_N, and PRES unchanged.
REQ-021 SHALL, on an overflow with SBY=0 and WT/IT=0 (interval mode), set OVF; ITI_IRQ SHALL equal OVF.
REQ-022 SHALL, on an overflow with SBY=0 and WT/IT=1 (watchdog mode), set WOVF and drive WDTOVF_N low for 128 CE_R ticks.
REQ-023 SHALL apply the following precedence on simultaneous events:
- a CPU WTCNT write takes priority over a count tick in the same cycle;
- overflow set takes priority over a flag clear in the same cycle;
- a WDTOVF_N pulse in progress is not retriggered.
REQ-024 SHALL register read data on a CE_F tick when REG_SEL=1, IBUS_REQ=1, and IBUS_WE=0: REG_DO <= {WTCSR|8'h18, WTCNT, RSTCSR|8'h1F, RSTCSR|8'h1F}.
REQ-025 SHALL drive IBUS_DO = REG_SEL ? REG_DO : 32'h0.
REQ-026 SHALL hold WTCNT, prescaler, and flags while EN=0; the bus read path SHALL remain live while EN=0.

Reset
REQ-027 SHALL, when RST_N=0 on a clock edge, set WTCSR=8'h18, WTCNT=8'h00, RSTCSR=8'h1F, prescaler=0, WDT_OVF=0, WDTOVF_N=1, PRES=0, ITI_IRQ=0, REG_DO=0.
REQ-028 SHALL, on reset asserted mid-count or mid-pulse, abort all pulses immediately and produce no residual overflow.
REQ-029 SHALL NOT clear WOVF or RSTCSR when a PRES-initiated reset completes; only RST_N or the REQ-014 clear write SHALL clear them.

Configuration
REQ-030 SHALL, with macro SH7604_WDT_INTRESET_EN defined, assert PRES for RST_PULSE CE_R ticks on a watchdog-mode overflow with RSTE=1 (RSTS is recorded only).
REQ-031 SHALL, without SH7604_WDT_INTRESET_EN, tie PRES to 0, make RSTE and RSTS read 0, and ignore 8'h5A writes to RSTCSR.

Verification
REQ-032 SHALL cover interval overflow: write FE80 = 16'hA527 (TME=1, CKS=7), then 16'h5AFE -> OVF=1 and ITI_IRQ=1 after 2*8192 ticks; write 16'hA527 -> both clear.
REQ-033 SHALL cover watchdog overflow: write 16'hA567, 16'h5AFF -> WOVF=1, WDTOVF_N low for 128 ticks, FE83 reads 8'h9F.
REQ-034 SHALL cover standby: SBY=1, TME=0, CKS=0, WTCNT=8'hFD -> exactly one WDT_OVF pulse after 3 count ticks; OVF=0 and WOVF=0.
REQ-035 SHALL cover keyed writes: write 16'h1234 to FE80 -> no register changes; word write 16'hA500 at FE82 while WOVF=1 -> WOVF=0.
REQ-036 SHALL cover simultaneous events: WTCNT write 8'h10 coincident with a tick -> WTCNT=8'h10; OVF clear coincident with overflow -> OVF=1.
REQ-037 SHALL cover internal reset (macro defined): RSTE=1, watchdog overflow -> PRES high for 512 ticks; RST_N low mid-pulse -> PRES=0 next edge.

Source files
------------

// File: rtl/sh7604_wdt.sv
// SH7604 watchdog timer: WTCSR/WTCNT/RSTCSR register block at FFFFFE80..FFFFFE83.
// Define SH7604_WDT_INTRESET_EN to enable the internal reset request (PRES) and RSTE/RSTS.
module sh7604_wdt #(
  parameter int unsigned RST_PULSE = 512
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        EN,
  input  logic [31:0] IBUS_A,
  input  logic [31:0] IBUS_DI,
  output logic [31:0] IBUS_DO,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic        IBUS_BUSY,
  output logic        IBUS_ACT,
  input  logic        SBY,
  output logic        WDT_OVF,
  output logic        ITI_IRQ,
  output logic        WDTOVF_N,
  output logic        PRES
);

  logic        reg_sel, tick_en, tick, run;
  logic        wr, wr_hi, wr_lo, wr_cnt, wr_csr, wr_clr, wr_rst;
  logic        cnt_ovf, sb_ovf, it_ovf, wd_ovf;
  logic        ovf, wt_it, tme, wovf, rste, rsts, wdt_ovf;
  logic [2:0]  cks;
  logic [3:0]  tap;
  logic [7:0]  wtcnt, wtcsr, rstcsr, wdn_cnt;
  logic [12:0] presc, presc_nx;
  logic [31:0] reg_do;
  logic        unused_ok;

  assign reg_sel = IBUS_A[31:2] == 30'h3FFFFFA0;
  assign tick_en = CE_R & EN;

  assign wr     = tick_en & reg_sel & IBUS_REQ & IBUS_WE;
  assign wr_hi  = wr & (IBUS_BA == 4'b1100);
  assign wr_lo  = wr & (IBUS_BA == 4'b0011);
  assign wr_cnt = wr_hi & (IBUS_DI[31:24] == 8'h5A);
  assign wr_csr = wr_hi & (IBUS_DI[31:24] == 8'hA5);
  assign wr_clr = wr_lo & (IBUS_DI[15:0] == 16'hA500);
  assign wr_rst = wr_lo & (IBUS_DI[15:8] == 8'h5A);

  always_comb begin
    tap = 4'd0;
    case (cks)
      3'd0: tap = 4'd0;
      3'd1: tap = 4'd5;
      3'd2: tap = 4'd6;
      3'd3: tap = 4'd7;
      3'd4: tap = 4'd8;
      3'd5: tap = 4'd9;
      3'd6: tap = 4'd11;
      3'd7: tap = 4'd12;
    endcase
  end

  // A count tick is the selected prescaler bit falling on this increment.
  assign presc_nx = presc + 13'd1;
  assign tick     = tick_en & presc[tap] & ~presc_nx[tap];
  assign run      = tme | SBY;

  // A same-cycle WTCNT load replaces the tick, so it can never wrap.
  assign cnt_ovf = tick & run & (wtcnt == 8'hFF) & ~wr_cnt;
  assign sb_ovf  = cnt_ovf & SBY;
  assign it_ovf  = cnt_ovf & ~SBY & ~wt_it;
  assign wd_ovf  = cnt_ovf & ~SBY & wt_it;

  assign wtcsr  = {ovf, wt_it, tme, 2'b11, cks};
  assign rstcsr = {wovf, rste, rsts, 5'h1F};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc   <= '0;
      wtcnt   <= '0;
      ovf     <= 1'b0;
      wt_it   <= 1'b0;
      tme     <= 1'b0;
      cks     <= '0;
      wovf    <= 1'b0;
      wdt_ovf <= 1'b0;
      wdn_cnt <= '0;
      reg_do  <= '0;
    end else begin
      if (CE_R) wdt_ovf <= sb_ovf;
      if (tick_en) begin
        presc <= presc_nx;
        if (!run)        wtcnt <= '0;
        else if (wr_cnt) wtcnt <= IBUS_DI[23:16];
        else if (tick)   wtcnt <= wtcnt + 8'd1;
        if (wr_csr) begin
          wt_it <= IBUS_DI[22];
          tme   <= IBUS_DI[21];
          cks   <= IBUS_DI[18:16];
        end
        if (it_ovf)                       ovf <= 1'b1;
        else if (wr_csr && !IBUS_DI[23])  ovf <= 1'b0;
        if (wd_ovf)      wovf <= 1'b1;
        else if (wr_clr) wovf <= 1'b0;
        // An active WDTOVF_N strobe runs to completion without retriggering.
        if (wdn_cnt != '0) wdn_cnt <= wdn_cnt - 8'd1;
        else if (wd_ovf)   wdn_cnt <= 8'd128;
      end
      if (CE_F && reg_sel && IBUS_REQ && !IBUS_WE)
        reg_do <= {wtcsr, wtcnt, rstcsr, rstcsr};
    end
  end

`ifdef SH7604_WDT_INTRESET_EN
  localparam int unsigned PW = $clog2(RST_PULSE + 1);
  logic [PW-1:0] pres_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rste     <= 1'b0;
      rsts     <= 1'b0;
      pres_cnt <= '0;
    end else if (tick_en) begin
      if (wr_rst) begin
        rste <= IBUS_DI[6];
        rsts <= IBUS_DI[5];
      end
      if (pres_cnt != '0)        pres_cnt <= pres_cnt - PW'(1);
      else if (wd_ovf && rste)   pres_cnt <= PW'(RST_PULSE);
    end
  end

  assign PRES      = pres_cnt != '0;
  assign unused_ok = ^IBUS_A[1:0];
`else
  localparam int unsigned unused_rst_pulse = RST_PULSE;
  assign rste      = 1'b0;
  assign rsts      = 1'b0;
  assign PRES      = 1'b0;
  assign unused_ok = ^{IBUS_A[1:0], wr_rst};
`endif

  assign IBUS_DO   = reg_sel ? reg_do : 32'h0;
  assign IBUS_ACT  = reg_sel;
  assign IBUS_BUSY = 1'b0;
  assign WDT_OVF   = wdt_ovf;
  assign ITI_IRQ   = ovf;
  assign WDTOVF_N  = wdn_cnt == '0;

endmodule
